pl_lsu_mem: RTL and testbench
=============================

PL_LSU_MEM -- requirements
Module: pl_lsu_mem

Memory-stage load/store unit; consumes the EX->MEM pipeline register outputs and drives the data-memory bus.

Interface
REQ-001 clk  input  1  pipeline clock; all state SHALL update on its rising edge.
REQ-002 reset  input  1  SHALL be synchronous and active-high.
REQ-003 MemWriteM  input  1  store request for the instruction in the memory stage.
REQ-004 ResultSrcM  input  2  load request when equal to 2'b01.
REQ-005 ALUResultM  input  32  effective byte address.
REQ-006 WriteDataM  input  32  store data, right-aligned.
REQ-007 InstrM  input  32  instruction; funct3 = InstrM[14:12].
REQ-008 mem_req, mem_we  output  1 each  bus request and write enable; both registered.
REQ-009 mem_addr, mem_wdata  output  32 each  word-aligned address and lane-replicated write data.
REQ-010 mem_be  output  4  byte-lane enables.
REQ-011 mem_ack  input  1  one-cycle completion strobe from memory.
REQ-012 mem_rdata  input  32  read word, valid with mem_ack.
REQ-013 ReadDataM  output  32  formatted load result, registered.
REQ-014 StallM  output  1  holds IF/ID/EX/EM registers while high.
REQ-015 MisalignM  output  1  one-cycle misaligned/illegal-access pulse.
REQ-016 BusErrM  output  1  sticky bus-timeout flag.

Function
REQ-017 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-018 Access is a store when MemWriteM=1, else a load when ResultSrcM=2'b01; store SHALL take priority if both are set.
REQ-019 Legal funct3: loads 000/001/010/100/101; stores 000/001/010; anything else SHALL be illegal.
REQ-020 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 IDLE, illegal or misaligned access: MisalignM=1 for that cycle, no bus request, StallM=0, ReadDataM<=0, state stays IDLE.
REQ-022 IDLE, legal access: StallM=1 combinationally; on the next edge register mem_req=1, mem_we, mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata, and capture funct3/addr[1:0]; go to REQ.
REQ-023 Byte store: mem_wdata={4{wd[7:0]}}, mem_be=4'b0001<<addr[1:0]. Halfword: {2{wd[15:0]}}, mem_be=4'b0011<<(2*addr[1]). Word: mem_wdata=wd, mem_be=4'b1111.
REQ-024 REQ: StallM=1; mem_req and all bus outputs SHALL stay stable until mem_ack.
REQ-025 REQ with mem_ack=1: mem_req<=0; on a load, ReadDataM<= mem_rdata lane selected by captured addr[1:0], sign-extended (lb/lh) or zero-extended (lbu/lhu/lw); on a store ReadDataM unchanged; go to DONE.
REQ-026 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack; at 255 it SHALL set BusErrM=1, drop mem_req, force ReadDataM<=0, and go to DONE.
REQ-027 DONE: StallM=0, ReadDataM valid; next state IDLE unconditionally. DONE SHALL NOT start a new access.
REQ-028 Minimum latency with zero-wait ack: StallM high for 2 cycles, data valid in the 3rd.
REQ-029 mem_ack outside REQ SHALL be ignored.
REQ-030 BusErrM SHALL clear only on reset.

Reset
REQ-031 On reset, the state SHALL go to IDLE and mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM, MisalignM, BusErrM, and the wait counter SHALL all be 0.
REQ-032 StallM SHALL be 0 while reset is asserted.
REQ-033 Reset asserted in REQ SHALL abort the access; a late mem_ack SHALL be ignored.

Verification
REQ-034 lw at 0x100 with mem_rdata=0xDEADBEEF and ack in the first REQ cycle -> StallM high for 2 cycles, ReadDataM=0xDEADBEEF in DONE, mem_be=4'hF.
REQ-035 lb at 0x103 with mem_rdata=0x80000000 -> ReadDataM=0xFFFFFF80; lbu -> 0x00000080.
REQ-036 sh at 0x202, WriteDataM=0x1234ABCD -> mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-037 lw at 0x101 -> MisalignM pulse for 1 cycle, mem_req never asserted, StallM=0.
REQ-038 Load with no mem_ack -> after 255 REQ cycles BusErrM=1, ReadDataM=0, StallM falls; reset asserted mid-REQ on a second load -> mem_req=0 on the next cycle.

Source files
------------

// File: rtl/pl_lsu_mem.sv
// Memory-stage load/store unit: turns the EX->MEM register contents into one
// data-bus transaction at a time, stalling the pipeline until it completes.
//
// state | meaning
// IDLE  | no bus activity; decode the access presented by the pipeline
// REQ   | request on the bus, waiting for mem_ack or the wait-counter timeout
// DONE  | load result valid on ReadDataM; release the stall for one cycle
module pl_lsu_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] InstrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state_q;
    logic        req_q, we_q, berr_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [7:0]  wait_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic [2:0]  funct3;
    logic        is_store, is_load, access, f3_legal, misaligned, bad;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_fmt;
    logic [15:0] lane;
    logic [7:0]  wait_inc;
    logic        unused_instr;

    assign funct3       = InstrM[14:12];
    assign unused_instr = ^{InstrM[31:15], InstrM[11:0]};
    assign wait_inc     = wait_q + 8'd1;

    always_comb begin
        is_store   = MemWriteM;
        is_load    = !MemWriteM && (ResultSrcM == 2'b01);
        access     = is_store || is_load;
        if (is_store)
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        misaligned = ((funct3[1:0] == 2'b01) && ALUResultM[0]) ||
                     ((funct3[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
        bad        = access && (!f3_legal || misaligned);

        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = WriteDataM;
            end
        endcase
    end

    // Lane select uses the offset captured at request time, not the live address.
    always_comb begin
        lane = 16'(mem_rdata >> {off_q, 3'b000});
        case (f3_q)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'd0, lane[7:0]};
            3'b101:  load_fmt = {16'd0, lane[15:0]};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            berr_q  <= 1'b0;
            wait_q  <= 8'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bad) begin
                        rdata_q <= 32'd0;
                    end else if (access) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {ALUResultM[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        f3_q    <= funct3;
                        off_q   <= ALUResultM[1:0];
                        wait_q  <= 8'd0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        if (!we_q)
                            rdata_q <= load_fmt;
                        state_q <= S_DONE;
                    end else if (wait_inc == 8'd255) begin
                        // Bus never answered: abandon the access with a zero result.
                        berr_q  <= 1'b1;
                        req_q   <= 1'b0;
                        rdata_q <= 32'd0;
                        wait_q  <= wait_inc;
                        state_q <= S_DONE;
                    end else begin
                        wait_q  <= wait_inc;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign StallM    = !reset && (((state_q == S_IDLE) && access && !bad) || (state_q == S_REQ));
    assign MisalignM = !reset && (state_q == S_IDLE) && bad;

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign ReadDataM = rdata_q;
    assign BusErrM   = berr_q;

endmodule

// File: tb/tb_pl_lsu_mem.sv
// Directed bench for pl_lsu_mem: a transaction-level model sets per-cycle
// expectations, a negedge process compares, literal checks pin key results.
module tb_pl_lsu_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, InstrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;

    always #5 clk = ~clk;

    pl_lsu_mem dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .InstrM(InstrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    int checks = 0;
    int errors = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_mis, exp_req, exp_we, exp_berr;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;
    int          stall_cnt, mis_cnt;
    bit          req_seen;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: access rules expressed as plain arithmetic ----
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (st) ok = (f3 <= 3'd2);
        else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return ok && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << m_size(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (a % 4));
        if (m_size(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (m_size(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---- per-cycle compare ----
    always @(negedge clk) begin
        if (StallM)    stall_cnt++;
        if (MisalignM) mis_cnt++;
        if (mem_req)   req_seen = 1'b1;
        if (chk_en) begin
            chk("StallM",    {31'd0, StallM},    {31'd0, exp_stall});
            chk("MisalignM", {31'd0, MisalignM}, {31'd0, exp_mis});
            chk("mem_req",   {31'd0, mem_req},   {31'd0, exp_req});
            chk("BusErrM",   {31'd0, BusErrM},   {31'd0, exp_berr});
            chk("ReadDataM", ReadDataM, exp_rd);
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be",   {28'd0, mem_be}, {28'd0, exp_be});
                chk("mem_we",   {31'd0, mem_we}, {31'd0, exp_we});
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        InstrM     = 32'h0000_0013;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    // ack_wait: REQ cycle index carrying mem_ack, negative for never.
    task automatic do_access(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int ack_wait);
        bit st, acked;
        st = we;
        stall_cnt = 0; mis_cnt = 0; req_seen = 1'b0; acked = 1'b0;
        MemWriteM = we; ResultSrcM = rs; ALUResultM = addr; WriteDataM = wd;
        InstrM = {17'd0, f3, 5'd1, 7'h03};
        mem_ack = 1'b0;
        exp_req = 1'b0;
        if (!m_legal(st, f3, addr)) begin
            exp_stall = 1'b0; exp_mis = 1'b1;
            step();
            idle_inputs();
            exp_mis = 1'b0; exp_rd = 32'd0;
            return;
        end
        exp_stall = 1'b1; exp_mis = 1'b0;
        step();
        exp_req = 1'b1; exp_we = st; exp_addr = addr & ~32'd3;
        exp_be = m_be(f3, addr); exp_wdata = m_wdata(f3, wd);
        snap_addr = mem_addr; snap_be = mem_be; snap_wdata = mem_wdata; snap_we = mem_we;
        for (int k = 0; k < 255; k++) begin
            mem_ack   = (k == ack_wait);
            mem_rdata = (k == ack_wait) ? rdata : 32'h5A5A_A5A5;
            step();
            if (k == ack_wait) begin
                acked = 1'b1;
                break;
            end
        end
        mem_ack = 1'b0; exp_req = 1'b0; exp_stall = 1'b0;
        if (!acked) begin
            exp_berr = 1'b1; exp_rd = 32'd0;
        end else if (!st) begin
            exp_rd = m_load(f3, addr, rdata);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        exp_stall = 0; exp_mis = 0; exp_req = 0; exp_we = 0; exp_berr = 0;
        exp_addr = 0; exp_wdata = 0; exp_rd = 0; exp_be = 0;
        MemWriteM = 1'b1; InstrM = 32'h0000_2023;   // a store held during reset must not stall
        repeat (3) step();
        chk_en = 1'b1;
        step();
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be",    {28'd0, mem_be}, 32'd0);
        chk("rst_we",    {31'd0, mem_we}, 32'd0);
        reset = 1'b0;
        idle_inputs();
        step();

        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;   // stray ack in IDLE
        step();
        ResultSrcM = 2'b10; InstrM = 32'h0000_3003;  // not a memory access
        mem_ack = 1'b0;
        step();
        idle_inputs();
        step();

        do_access(1'b0, 2'b01, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0);
        chk("lw_stall_cycles", stall_cnt, 2);
        chk("lw_be", {28'd0, snap_be}, 32'h0000_000F);
        chk("lw_data", ReadDataM, 32'hDEAD_BEEF);

        do_access(1'b0, 2'b01, 3'b000, 32'h103, 32'd0, 32'h8000_0000, 0);
        chk("lb_data", ReadDataM, 32'hFFFF_FF80);
        do_access(1'b0, 2'b01, 3'b100, 32'h103, 32'd0, 32'h8000_0000, 1);
        chk("lbu_data", ReadDataM, 32'h0000_0080);

        do_access(1'b1, 2'b00, 3'b001, 32'h202, 32'h1234_ABCD, 32'd0, 2);
        chk("sh_addr",  snap_addr, 32'h0000_0200);
        chk("sh_be",    {28'd0, snap_be}, 32'h0000_000C);
        chk("sh_wdata", snap_wdata, 32'hABCD_ABCD);
        chk("sh_we",    {31'd0, snap_we}, 32'd1);
        chk("sh_keeps_rd", ReadDataM, 32'h0000_0080);

        do_access(1'b1, 2'b00, 3'b000, 32'h001, 32'h0000_0055, 32'd0, 1);
        do_access(1'b0, 2'b01, 3'b001, 32'h002, 32'd0, 32'h8001_7FFF, 0);
        chk("lh_data", ReadDataM, 32'hFFFF_8001);
        do_access(1'b0, 2'b01, 3'b101, 32'h000, 32'd0, 32'h8001_7FFF, 3);
        do_access(1'b1, 2'b00, 3'b010, 32'h010, 32'hCAFE_F00D, 32'd0, 0);
        do_access(1'b1, 2'b01, 3'b010, 32'h020, 32'h0BAD_CAFE, 32'd0, 0);
        chk("store_priority_we", {31'd0, snap_we}, 32'd1);

        do_access(1'b0, 2'b01, 3'b010, 32'h101, 32'd0, 32'd0, 0);
        chk("mis_pulses", mis_cnt, 1);
        chk("mis_no_req", {31'd0, req_seen}, 32'd0);
        chk("mis_no_stall", stall_cnt, 0);
        step();
        do_access(1'b0, 2'b01, 3'b011, 32'h100, 32'd0, 32'd0, 0);
        do_access(1'b1, 2'b01, 3'b100, 32'h100, 32'h1, 32'd0, 0);
        do_access(1'b1, 2'b00, 3'b001, 32'h201, 32'h1, 32'd0, 0);
        step();

        do_access(1'b0, 2'b01, 3'b010, 32'h300, 32'd0, 32'd0, -1);
        chk("to_stall_cycles", stall_cnt, 256);
        chk("to_buserr", {31'd0, BusErrM}, 32'd1);
        chk("to_data", ReadDataM, 32'd0);
        do_access(1'b0, 2'b01, 3'b010, 32'h304, 32'd0, 32'h1357_9BDF, 1);
        chk("buserr_sticky", {31'd0, BusErrM}, 32'd1);

        // reset in the middle of a request, with an ack arriving too late
        MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h400;
        InstrM = 32'h0000_2083;
        exp_stall = 1'b1;
        step();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h400; exp_be = 4'hF;
        step();
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        exp_stall = 1'b0;
        step();
        reset = 1'b0;
        idle_inputs();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        exp_req = 1'b0; exp_rd = 32'd0; exp_berr = 1'b0;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        step();
        mem_ack = 1'b0;
        step();
        chk("late_ack_rd", ReadDataM, 32'd0);
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        step();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
